// File: rtl/line_assembler_pkg.sv
// Shared definitions for the bench command receive path: ASCII constants,
// the line-assembler FSM state and the byte classes seen by the classifier.
package bench_line_pkg;

  localparam int         DEF_LINE_CHARS = 16;

  localparam logic [7:0] ASCII_CR  = 8'h0D;
  localparam logic [7:0] ASCII_LF  = 8'h0A;
  localparam logic [7:0] ASCII_BS  = 8'h08;
  localparam logic [7:0] ASCII_DEL = 8'h7F;
  localparam logic [7:0] ASCII_BEL = 8'h07;
  localparam logic [7:0] ASCII_SP  = 8'h20;

  typedef enum logic {
    ST_FILL   = 1'b0,
    ST_GOT_CR = 1'b1
  } line_state_e;

  typedef enum logic [1:0] {
    CLS_STORE = 2'd0,
    CLS_ERASE = 2'd1,
    CLS_TERM  = 2'd2,
    CLS_SKIP  = 2'd3
  } char_class_e;

endpackage

// File: rtl/line_assembler_if.sv
// Byte-in / line-out bundle for line_assembler.
// Echo signals exist only when LINE_ASSEMBLER_ECHO_EN is defined.
interface line_assembler_if #(
  parameter int LINE_CHARS = 16
);
  logic [7:0]              rx_data;
  logic                    rx_valid;
  logic [8*LINE_CHARS-1:0] buffer;
  logic                    buffer_valid;
  logic                    buffer_overflow;
`ifdef LINE_ASSEMBLER_ECHO_EN
  logic [7:0]              echo_data;
  logic                    echo_valid;
`endif

  // Byte source / line consumer side
  modport master (
    output rx_data, rx_valid,
`ifdef LINE_ASSEMBLER_ECHO_EN
    input  echo_data, echo_valid,
`endif
    input  buffer, buffer_valid, buffer_overflow
  );

  // Line assembler side
  modport slave (
    input  rx_data, rx_valid,
`ifdef LINE_ASSEMBLER_ECHO_EN
    output echo_data, echo_valid,
`endif
    output buffer, buffer_valid, buffer_overflow
  );
endinterface

// File: rtl/line_assembler_char_class.sv
// Combinational byte classifier: maps a received byte and the FSM state to
// store / erase / terminate / skip.
import bench_line_pkg::*;

module line_char_class (
  input  logic [7:0]  rx_data,
  input  line_state_e state,
  output char_class_e cls
);

  // LF directly after CR is the second half of a CRLF pair and is skipped.
  always_comb begin
    cls = CLS_SKIP;
    if (rx_data >= ASCII_SP && rx_data < ASCII_DEL)
      cls = CLS_STORE;
    else if (rx_data == ASCII_BS || rx_data == ASCII_DEL)
      cls = CLS_ERASE;
    else if (rx_data == ASCII_CR)
      cls = CLS_TERM;
    else if (rx_data == ASCII_LF && state == ST_FILL)
      cls = CLS_TERM;
  end

endmodule

// File: rtl/line_assembler.sv
// line_assembler: collects ASCII bytes into a left-aligned, pad-filled line
// and emits it as a wide buffer with a one-cycle strobe on CR or LF.
// Optional echo path enabled by defining LINE_ASSEMBLER_ECHO_EN.
import bench_line_pkg::*;

module line_assembler #(
  parameter int         LINE_CHARS = DEF_LINE_CHARS,
  parameter logic [7:0] PAD_CHAR   = 8'h20
) (
  input logic         clk,
  input logic         rst,
  line_assembler_if.slave bus
);

  localparam int CW = $clog2(LINE_CHARS + 1);
  localparam logic [8*LINE_CHARS-1:0] PAD_LINE = {LINE_CHARS{PAD_CHAR}};

  logic [8*LINE_CHARS-1:0] line_q;
  logic [CW-1:0]           count_q;
  logic                    ovf_q;
  line_state_e             state_q;
  char_class_e             cls;
  logic                    full;
  logic [CW-1:0]           slot;

  line_char_class u_class (
    .rx_data (bus.rx_data),
    .state   (state_q),
    .cls     (cls)
  );

  // Slot addressed by this byte: next free slot on store, last used on erase.
  always_comb begin
    full = (count_q == CW'(LINE_CHARS));
    slot = count_q;
    if (cls == CLS_ERASE)
      slot = count_q - 1'b1;
  end

  // Line registers, FSM, emit strobes and (optionally) echo, all registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      line_q              <= PAD_LINE;
      count_q             <= '0;
      ovf_q               <= 1'b0;
      state_q             <= ST_FILL;
      bus.buffer          <= PAD_LINE;
      bus.buffer_valid    <= 1'b0;
      bus.buffer_overflow <= 1'b0;
`ifdef LINE_ASSEMBLER_ECHO_EN
      bus.echo_data       <= 8'h00;
      bus.echo_valid      <= 1'b0;
`endif
    end else begin
      bus.buffer_valid    <= 1'b0;
      bus.buffer_overflow <= 1'b0;
`ifdef LINE_ASSEMBLER_ECHO_EN
      bus.echo_valid      <= 1'b0;
`endif
      if (bus.rx_valid) begin
        state_q <= (bus.rx_data == ASCII_CR) ? ST_GOT_CR : ST_FILL;
        case (cls)
          CLS_STORE: begin
            if (!full) begin
              for (int k = 0; k < LINE_CHARS; k++)
                if (slot == CW'(k)) line_q[(LINE_CHARS-1-k)*8 +: 8] <= bus.rx_data;
              count_q <= count_q + 1'b1;
`ifdef LINE_ASSEMBLER_ECHO_EN
              bus.echo_data  <= bus.rx_data;
              bus.echo_valid <= 1'b1;
`endif
            end else begin
              ovf_q <= 1'b1;
`ifdef LINE_ASSEMBLER_ECHO_EN
              bus.echo_data  <= ASCII_BEL;
              bus.echo_valid <= 1'b1;
`endif
            end
          end
          CLS_ERASE: begin
            if (count_q != '0) begin
              for (int k = 0; k < LINE_CHARS; k++)
                if (slot == CW'(k)) line_q[(LINE_CHARS-1-k)*8 +: 8] <= PAD_CHAR;
              count_q <= count_q - 1'b1;
`ifdef LINE_ASSEMBLER_ECHO_EN
              bus.echo_data  <= ASCII_BS;
              bus.echo_valid <= 1'b1;
`endif
            end
          end
          CLS_TERM: begin
            if (count_q != '0) begin
              bus.buffer          <= line_q;
              bus.buffer_valid    <= 1'b1;
              bus.buffer_overflow <= ovf_q;
            end
            line_q  <= PAD_LINE;
            count_q <= '0;
            ovf_q   <= 1'b0;
`ifdef LINE_ASSEMBLER_ECHO_EN
            bus.echo_data  <= ASCII_CR;
            bus.echo_valid <= 1'b1;
`endif
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_line_assembler.sv
// Directed, table-driven bench for line_assembler. Each record is one cycle
// of input and the outputs expected in the following cycle.
module tb_line_assembler;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  line_assembler_if #(.LINE_CHARS(16)) bus ();

  line_assembler u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [7:0]   d;
    logic         v;
    logic         e_bv;
    logic         e_bo;
    logic [127:0] e_buf;
    logic         e_ev;
    logic [7:0]   e_ed;
  } vec_t;

  vec_t         vecs[$];
  logic [127:0] held;

  function automatic logic [127:0] line(input string s);
    logic [127:0] r;
    r = {16{8'h20}};
    for (int i = 0; i < s.len() && i < 16; i++) r[127-8*i -: 8] = s[i];
    return r;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] d, input logic v, input logic bv, input logic bo,
                      input logic [127:0] b, input logic ev, input logic [7:0] ed);
    vec_t t;
    t.d = d; t.v = v; t.e_bv = bv; t.e_bo = bo; t.e_buf = b; t.e_ev = ev; t.e_ed = ed;
    vecs.push_back(t);
  endtask

  // Printable characters that fit in the line: stored, echoed, no strobe.
  task automatic txt(input string s);
    for (int i = 0; i < s.len(); i++) push(s[i], 1'b1, 1'b0, 1'b0, held, 1'b1, s[i]);
  endtask

  // Terminator on a non-empty line.
  task automatic term(input logic [7:0] t, input string s, input logic bo);
    held = line(s);
    push(t, 1'b1, 1'b1, bo, held, 1'b1, 8'h0D);
  endtask

  task automatic drive_byte(input logic [7:0] d);
    @(negedge clk);
    bus.rx_data  = d;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  initial begin
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    held = line("");

    // "123\r" then a CRLF-paired LF
    txt("123"); term(8'h0D, "123", 1'b0);
    push(8'h0A, 1'b1, 1'b0, 1'b0, held, 1'b0, 8'h00);
    // "1\r\n2\n": LF after CR swallowed, bare LF terminates
    txt("1"); term(8'h0D, "1", 1'b0);
    push(8'h0A, 1'b1, 1'b0, 1'b0, held, 1'b0, 8'h00);
    txt("2"); term(8'h0A, "2", 1'b0);
    // "12<BS>3\r", then "<BS>\r" on an empty line
    txt("12"); push(8'h08, 1'b1, 1'b0, 1'b0, held, 1'b1, 8'h08);
    txt("3"); term(8'h0D, "13", 1'b0);
    push(8'h08, 1'b1, 1'b0, 1'b0, held, 1'b0, 8'h00);
    push(8'h0D, 1'b1, 1'b0, 1'b0, held, 1'b1, 8'h0D);
    // other control byte dropped, idle cycle
    push(8'h01, 1'b1, 1'b0, 1'b0, held, 1'b0, 8'h00);
    push(8'h41, 1'b0, 1'b0, 1'b0, held, 1'b0, 8'h00);
    // overflow: 18 printables, only 16 kept
    txt("ABCDEFGHIJKLMNOP");
    push("Q", 1'b1, 1'b0, 1'b0, held, 1'b1, 8'h07);
    push("R", 1'b1, 1'b0, 1'b0, held, 1'b1, 8'h07);
    term(8'h0D, "ABCDEFGHIJKLMNOP", 1'b1);
    txt("X"); term(8'h0D, "X", 1'b0);
    // DEL on a full line then refill the last slot
    txt("ABCDEFGHIJKLMNOP");
    push(8'h7F, 1'b1, 1'b0, 1'b0, held, 1'b1, 8'h08);
    txt("Z"); term(8'h0D, "ABCDEFGHIJKLMNOZ", 1'b0);
    // "a\r\r": second CR is an empty line
    txt("a"); term(8'h0D, "a", 1'b0);
    push(8'h0D, 1'b1, 1'b0, 1'b0, held, 1'b1, 8'h0D);
    // echo sequence: 16 x A, B (BEL), BS, CR; overflow flag survives the BS
    txt("AAAAAAAAAAAAAAAA");
    push("B", 1'b1, 1'b0, 1'b0, held, 1'b1, 8'h07);
    push(8'h08, 1'b1, 1'b0, 1'b0, held, 1'b1, 8'h08);
    term(8'h0D, "AAAAAAAAAAAAAAA", 1'b1);

    // reset state
    #12;
    check("reset_buf", bus.buffer, line(""));
    check("reset_bv", {127'd0, bus.buffer_valid}, 128'd0);
    check("reset_bo", {127'd0, bus.buffer_overflow}, 128'd0);
`ifdef LINE_ASSEMBLER_ECHO_EN
    check("reset_ev", {127'd0, bus.echo_valid}, 128'd0);
    check("reset_ed", {120'd0, bus.echo_data}, 128'd0);
`endif
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      bus.rx_data  = vecs[i].d;
      bus.rx_valid = vecs[i].v;
      @(posedge clk);
      #1;
      check($sformatf("v%0d_bv", i), {127'd0, bus.buffer_valid}, {127'd0, vecs[i].e_bv});
      check($sformatf("v%0d_bo", i), {127'd0, bus.buffer_overflow}, {127'd0, vecs[i].e_bo});
      check($sformatf("v%0d_buf", i), bus.buffer, vecs[i].e_buf);
`ifdef LINE_ASSEMBLER_ECHO_EN
      check($sformatf("v%0d_ev", i), {127'd0, bus.echo_valid}, {127'd0, vecs[i].e_ev});
      if (vecs[i].e_ev)
        check($sformatf("v%0d_ed", i), {120'd0, bus.echo_data}, {120'd0, vecs[i].e_ed});
`endif
    end
    @(negedge clk);
    bus.rx_valid = 1'b0;

    // Reset mid-line: "45" discarded, next line is "6"
    drive_byte("4");
    drive_byte("5");
    #2;
    rst = 1'b0;
    #1;
    check("rst_mid_buf", bus.buffer, line(""));
    check("rst_mid_bv", {127'd0, bus.buffer_valid}, 128'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    drive_byte("6");
    @(negedge clk);
    bus.rx_data  = 8'h0D;
    bus.rx_valid = 1'b1;
    @(posedge clk);
    #1;
    check("rst_6_bv", {127'd0, bus.buffer_valid}, 128'd1);
    check("rst_6_buf", bus.buffer, line("6"));
    // Reset while the strobe is high drops it without a clock edge
    #1;
    rst = 1'b0;
    #1;
    check("rst_async_bv", {127'd0, bus.buffer_valid}, 128'd0);
    check("rst_async_buf", bus.buffer, line(""));
    @(negedge clk);
    bus.rx_valid = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/line_assembler.md
# line_assembler

Receive-side front end for the bench command path. Collects ASCII bytes from the UART receiver into a fixed-width, left-aligned, space-padded line register. On a line terminator it presents the completed line as a 128-bit `buffer` with a one-cycle `buffer_valid` strobe, which is exactly the form the bench command block consumes. It also handles backspace editing, CR/LF pairing, empty-line suppression and overflow.

## Interface
- `LINE_CHARS`, 16: characters per line. Buffer width is 8*`LINE_CHARS`.
- `PAD_CHAR`, 8'h20: fill byte for unused character slots.

- `clk`, in, 1: single clock. All logic is on the rising edge.
- `rst`, in, 1: reset, asynchronous, active-low.
- `rx_data`, in, 8: received byte.
- `rx_valid`, in, 1: single-cycle strobe. It may be asserted on consecutive cycles and there is no backpressure.
- `buffer`, out, 8*`LINE_CHARS`: last completed line. The first character is in [MSB -: 8] and slot k is in [MSB-8k -: 8].
- `buffer_valid`, out, 1: one-cycle strobe for a new line.
- `buffer_overflow`, out, 1: one-cycle strobe, coincident with `buffer_valid`, when that line was truncated.
- `echo_data`, out, 8: echo byte. Present only with `LINE_ASSEMBLER_ECHO_EN`.
- `echo_valid`, out, 1: echo strobe. Present only with `LINE_ASSEMBLER_ECHO_EN`.

## Operation
- Internal state:
  - assembly register `line_q` (all `PAD_CHAR` at reset);
  - character count `count_q`, 0..`LINE_CHARS`;
  - overflow flag `ovf_q`;
  - FSM {FILL, GOT_CR}.
- Byte classes, evaluated only when `rx_valid`=1:
  - Printable 0x20–0x7E, with `count_q`<`LINE_CHARS`: store at slot `count_q`, increment the count.
  - Printable, with the line full: drop the byte and set `ovf_q`.
  - BS 0x08 / DEL 0x7F, with `count_q`>0: decrement the count and rewrite that slot with `PAD_CHAR`.
  - BS / DEL, with `count_q`=0: ignore.
  - CR 0x0D, or LF 0x0A in state FILL: terminator.
  - LF in state GOT_CR: swallowed. The FSM returns to FILL with no other effect.
  - Any other control byte: dropped.
- FSM transitions:
  - Any accepted byte other than CR leads to FILL.
  - CR leads to GOT_CR.
  - Idle cycles do not change the state.
- Terminator handling:
  - If `count_q`>0: copy `line_q` to `buffer` and pulse `buffer_valid`. Pulse `buffer_overflow` if `ovf_q`=1.
  - In the same edge, reset `line_q` to all pad, `count_q` to 0 and `ovf_q` to 0.
  - If `count_q`=0, the line is empty: no strobe, and `buffer` is unchanged.
- `buffer` holds its value until the next emitted line.
- Reset values:
  - `buffer` all `PAD_CHAR`;
  - `buffer_valid`, `buffer_overflow`, `echo_valid` = 0;
  - `echo_data` = 0x00;
  - FSM in FILL.

## Timing
- A terminator sampled at edge N produces `buffer_valid`/`buffer_overflow` high during cycle N+1 only. `buffer` is already valid during that cycle.
- Operation has zero bubble. A byte sampled at edge N+1 goes into the fresh line.
- A back-to-back terminator (e.g. "\r\r") gives at most one strobe, because the second line is empty.
- A printable byte that arrives when the line is full does not change `line_q`.
- Reset asserted mid-line discards the partial line immediately, without waiting for a clock edge. Strobes drop asynchronously.
- The count never wraps. It saturates at `LINE_CHARS`, and a BS at a full line reduces it to `LINE_CHARS`-1.

## Configuration
- `LINE_ASSEMBLER_ECHO_EN` defined: `echo_data`/`echo_valid` exist. Each byte sampled at edge N gives an echo in cycle N+1:
  - stored printable: the byte itself;
  - accepted BS/DEL: 0x08;
  - terminator: 0x0D;
  - dropped overflow printable: BEL 0x07;
  - swallowed LF, ignored BS, and other control bytes: no echo.
- `LINE_ASSEMBLER_ECHO_EN` undefined: the echo ports and echo logic are absent. The line behaviour is identical in both builds.

## Structure
- Shared package `bench_line_pkg` holds:
  - ASCII constants CR, LF, BS, DEL, BEL, SP;
  - the FSM state typedef;
  - the default `LINE_CHARS`.
- One combinational sub-module, `line_char_class`. It maps `rx_data` and the FSM state to a class: STORE, ERASE, TERM, SKIP.
- The top module holds the registers, the slot-write/erase logic and the emit logic.

## Test plan
- "123\r" → one `buffer_valid` in the cycle after CR; `buffer` = 0x313233 followed by 13×0x20; `buffer_overflow`=0.
- "1\r\n2\n" → exactly two strobes, with lines "1" and "2" padded. The LF after the CR produces no strobe and no empty line.
- "12\x083\r" → `buffer` = "13" + 14×0x20. Also "\x08\r" alone → no strobe.
- "ABCDEFGHIJKLMNOPQR\r" → `buffer` = "ABCDEFGHIJKLMNOP"; `buffer_valid` and `buffer_overflow` high in the same cycle. The next line "X\r" has `buffer_overflow`=0.
- "45", then `rst` low for 2 cycles, then "6\r" → `buffer` = "6" + 15×0x20. `buffer_valid` is 0 during reset and `buffer` resets to all pad.
- With `LINE_ASSEMBLER_ECHO_EN`: 16 × "A", then "B", then "\x08", then "\r" → echoes are 0x41×16, 0x07, 0x08, 0x0D, each one cycle after its input.
